// File: rtl/mux_sel_pkg.sv
// Shared types and constants for the LED mux select-line scanner.
package mux_sel_pkg;

  localparam int SEL_W = 2;
  localparam logic [SEL_W-1:0] SEL_MAX = 2'd3;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_AUTO   = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/mux_sel_scanner_key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, optional debouncer, rising-edge pulse.
// Debouncer is compiled in only when MUX_SEL_SCANNER_DEBOUNCE_EN is defined.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic pulse
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("key_debounce: DEBOUNCE_CYCLES must be at least 1");
  end

  logic       sync0, sync1;
  logic       level, level_prev;
  logic       armed;
  logic [1:0] fill;

  // armed stays low until the synchronized key has been seen released, so a
  // button held through reset cannot produce a step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0      <= 1'b0;
      sync1      <= 1'b0;
      fill       <= 2'b00;
      armed      <= 1'b0;
      level_prev <= 1'b0;
    end else begin
      sync0      <= key;
      sync1      <= sync0;
      fill       <= {fill[0], 1'b1};
      armed      <= armed | (fill[1] & ~sync1);
      level_prev <= level;
    end
  end

`ifdef MUX_SEL_SCANNER_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync1 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_TC) begin
      cnt   <= '0;
      level <= sync1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign level = sync1;
`endif

  assign pulse = level & ~level_prev & armed;

endmodule

// File: rtl/mux_sel_scanner.sv
// Select-line generator for the 4:1 LED mux: manual button steps, auto-scan, or hold.
// Build option: MUX_SEL_SCANNER_DEBOUNCE_EN enables the STEP debouncer.
module mux_sel_scanner
  import mux_sel_pkg::*;
#(
  parameter int PRESCALE        = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             STEP,
  input  logic             MODE,
  input  logic             HOLD,
  output logic [SEL_W-1:0] SEL,
  output logic             SEL_STB,
  output logic [1:0]       STATE
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRESC_TC = PW'(PRESCALE - 1);

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [SEL_W-1:0] sel_d;
  logic             stb_d;
  logic             step_pulse;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step (
    .clk  (CLOCK_50),
    .rst  (RESET),
    .key  (STEP),
    .pulse(step_pulse)
  );

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_MANUAL;
      presc_q <= '0;
      SEL     <= '0;
      SEL_STB <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      SEL     <= sel_d;
      SEL_STB <= stb_d;
    end
  end

  // Actions are gated by both current and next state, so a HOLD or MODE change
  // arriving this cycle overrides a pending terminal count or button step.
  always_comb begin
    state_d = ST_MANUAL;
    presc_d = presc_q;
    sel_d   = SEL;
    stb_d   = 1'b0;

    case (state_q)
      ST_MANUAL, ST_AUTO, ST_HOLD: begin
        if (HOLD)      state_d = ST_HOLD;
        else if (MODE) state_d = ST_AUTO;
        else           state_d = ST_MANUAL;
      end
      default: state_d = ST_MANUAL;
    endcase

    if (state_d == ST_AUTO) begin
      if (state_q != ST_AUTO) begin
        presc_d = '0;
      end else if (presc_q == PRESC_TC) begin
        presc_d = '0;
        stb_d   = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end else if (state_d == ST_MANUAL && state_q == ST_MANUAL) begin
      stb_d = step_pulse;
    end

    if (stb_d) sel_d = (SEL == SEL_MAX) ? '0 : SEL + 1'b1;
  end

  assign STATE = state_q;

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Directed self-checking bench for mux_sel_scanner (PRESCALE=4, DEBOUNCE_CYCLES=3).
module tb_mux_sel_scanner;

  localparam int PRESCALE        = 4;
  localparam int DEBOUNCE_CYCLES = 3;
`ifdef MUX_SEL_SCANNER_DEBOUNCE_EN
  localparam int STEP_LAT     = 6;
  localparam int BOUNCE_STEPS = 1;
`else
  localparam int STEP_LAT     = 3;
  localparam int BOUNCE_STEPS = 3;
`endif

  logic       clk = 1'b0;
  logic       rst, step, mode, hold;
  logic [1:0] sel, state;
  logic       sel_stb;

  int n_assert = 0;
  int n_fail   = 0;
  int stb_cnt  = 0;

  mux_sel_scanner #(
    .PRESCALE       (PRESCALE),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .CLOCK_50(clk),
    .RESET   (rst),
    .STEP    (step),
    .MODE    (mode),
    .HOLD    (hold),
    .SEL     (sel),
    .SEL_STB (sel_stb),
    .STATE   (state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [1:0] prev_sel, input logic [1:0] new_sel);
    step = 1'b1;
    tick(STEP_LAT - 1);
    check("press_early_sel", 8'(sel), 8'(prev_sel));
    check("press_early_stb", 8'(sel_stb), 8'd0);
    tick(1);
    check("press_sel", 8'(sel), 8'(new_sel));
    check("press_stb", 8'(sel_stb), 8'd1);
    tick(1);
    check("press_stb_single", 8'(sel_stb), 8'd0);
    tick(10 - STEP_LAT - 1);
    step = 1'b0;
    tick(10);
    check("press_after_release_sel", 8'(sel), 8'(new_sel));
    check("press_after_release_stb", 8'(sel_stb), 8'd0);
  endtask

  initial begin
    rst  = 1'b1;
    step = 1'b0;
    mode = 1'b0;
    hold = 1'b0;
    tick(3);
    rst = 1'b0;
    check("reset_sel", 8'(sel), 8'd0);
    check("reset_stb", 8'(sel_stb), 8'd0);
    check("reset_state", 8'(state), 8'd0);

    for (int i = 1; i <= 20; i++) begin
      tick(1);
      check("idle_sel", 8'(sel), 8'd0);
      check("idle_stb", 8'(sel_stb), 8'd0);
      check("idle_state", 8'(state), 8'd0);
    end

    press(2'd0, 2'd1);
    press(2'd1, 2'd2);
    press(2'd2, 2'd3);
    press(2'd3, 2'd0);

    // bounce 1-0-1-0 two cycles each, then held high, then released
    stb_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (i < 8)       step = ((i / 2) % 2 == 0);
      else if (i < 30) step = 1'b1;
      else             step = 1'b0;
      tick(1);
      stb_cnt += int'(sel_stb);
    end
    check("bounce_strobes", 8'(stb_cnt), 8'(BOUNCE_STEPS));
    check("bounce_sel", 8'(sel), 8'(BOUNCE_STEPS));

    rst = 1'b1;
    #1;
    check("async_reset_sel", 8'(sel), 8'd0);
    check("async_reset_state", 8'(state), 8'd0);
    tick(1);
    rst = 1'b0;

    // auto-scan from a clean MANUAL/SEL=0 start
    mode = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      tick(1);
      check("auto_state", 8'(state), 8'd1);
      check("auto_stb", 8'(sel_stb), 8'((i > 1) && ((i - 1) % 4 == 0)));
      check("auto_sel", 8'(sel), 8'(((i - 1) / 4) % 4));
    end

    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(5);
    check("hold_pre_sel", 8'(sel), 8'd1);
    check("hold_pre_stb", 8'(sel_stb), 8'd1);
    tick(2);
    hold = 1'b1;
    for (int i = 8; i <= 17; i++) begin
      tick(1);
      check("hold_sel", 8'(sel), 8'd1);
      check("hold_stb", 8'(sel_stb), 8'd0);
      check("hold_state", 8'(state), 8'd2);
    end
    hold = 1'b0;
    for (int i = 18; i <= 21; i++) begin
      tick(1);
      check("rehold_state", 8'(state), 8'd1);
      check("rehold_stb", 8'(sel_stb), 8'd0);
      check("rehold_sel", 8'(sel), 8'd1);
    end
    tick(1);
    check("rehold_first_stb", 8'(sel_stb), 8'd1);
    check("rehold_first_sel", 8'(sel), 8'd2);

    // prescaler now at 3 with SEL=2; reset must clear it immediately
    tick(3);
    check("midreset_pre_sel", 8'(sel), 8'd2);
    rst = 1'b1;
    #1;
    check("midreset_sel", 8'(sel), 8'd0);
    check("midreset_state", 8'(state), 8'd0);
    check("midreset_stb", 8'(sel_stb), 8'd0);
    tick(2);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      check("postreset_stb", 8'(sel_stb), 8'd0);
      check("postreset_sel", 8'(sel), 8'd0);
      check("postreset_state", 8'(state), 8'd1);
    end
    tick(1);
    check("postreset_first_stb", 8'(sel_stb), 8'd1);
    check("postreset_first_sel", 8'(sel), 8'd1);

    // HOLD rising in the terminal-count cycle wins
    tick(3);
    hold = 1'b1;
    tick(1);
    check("hold_tc_sel", 8'(sel), 8'd1);
    check("hold_tc_stb", 8'(sel_stb), 8'd0);
    check("hold_tc_state", 8'(state), 8'd2);
    tick(3);
    check("hold_tc_later_sel", 8'(sel), 8'd1);

    hold = 1'b0;
    mode = 1'b0;
    tick(2);
    check("final_state", 8'(state), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
